// File: rtl/seg_pkg.sv
// Shared constants and frame-buffer entry type for the 7-segment frame controller.
`timescale 1ns/1ps
package seg_pkg;
    localparam int DIGITS = 8;
    localparam int SEG_W  = 7;
    localparam int DIG_W  = 3;
    localparam logic [SEG_W-1:0] BLANK_SEGS_DEFAULT = 7'h7F;

    typedef struct packed {
        logic [SEG_W-1:0] segs;
        logic             blink;
    } frame_entry_t;

    // Pattern actually shown for an entry: blinking digits go dark in the dark phase.
    function automatic logic [SEG_W-1:0] shown_segs(input frame_entry_t e, input logic phase,
                                                     input logic [SEG_W-1:0] blank);
        if (e.blink && phase) begin
            shown_segs = blank;
        end else begin
            shown_segs = e.segs;
        end
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the favoured requester on a tie.
`timescale 1ns/1ps
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    // Grant decode from request vector and tie-break pointer.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/seg_frame_ctrl.sv
// 8-digit 7-segment frame buffer with two arbitrated writers, clear and per-digit blink.
`timescale 1ns/1ps
module seg_frame_ctrl
    import seg_pkg::*;
#(
    parameter int               BLINK_HALF_CYCLES = 25000000,
    parameter logic [SEG_W-1:0] BLANK_SEGS        = BLANK_SEGS_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic [1:0]                   wr_valid,
    output logic [1:0]                   wr_ready,
    input  logic [1:0][DIG_W-1:0]        wr_digit,
    input  logic [1:0][SEG_W-1:0]        wr_segs,
    input  logic [1:0]                   wr_blink,
    output logic [DIGITS-1:0][SEG_W-1:0] segs_out,
    output logic                         blink_phase
);

    localparam int CNT_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam frame_entry_t BLANK_ENTRY = '{segs: BLANK_SEGS, blink: 1'b0};

    logic [1:0]                   grant_s;
    logic                         ptr_r;
    logic                         xfer_s;
    logic                         gnt_idx_s;
    frame_entry_t [DIGITS-1:0]    frame_r;
    frame_entry_t [DIGITS-1:0]    frame_nxt_s;
    logic [CNT_W-1:0]             blink_cnt_r;
    logic                         blink_phase_r;
    logic                         cnt_wrap_s;
    logic                         phase_nxt_s;
    logic [DIGITS-1:0][SEG_W-1:0] segs_nxt_s;
    logic [DIGITS-1:0][SEG_W-1:0] segs_out_r;

    rr_arb2 u_arb (
        .valid   (wr_valid),
        .pointer (ptr_r),
        .grant   (grant_s)
    );

    // Ready is the raw grant, suppressed during reset and clear so nothing transfers then.
    assign wr_ready    = grant_s & {2{rst_n & ~clr}};
    assign xfer_s      = |wr_ready;
    assign gnt_idx_s   = wr_ready[1];
    assign cnt_wrap_s  = (blink_cnt_r == CNT_W'(BLINK_HALF_CYCLES - 1));
    assign phase_nxt_s = blink_phase_r ^ cnt_wrap_s;

    // Next frame contents: clear wins over the granted write.
    always_comb begin
        frame_nxt_s = frame_r;
        if (clr) begin
            frame_nxt_s = {DIGITS{BLANK_ENTRY}};
        end else if (xfer_s) begin
            frame_nxt_s[wr_digit[gnt_idx_s]] = '{segs: wr_segs[gnt_idx_s], blink: wr_blink[gnt_idx_s]};
        end else begin
            frame_nxt_s = frame_r;
        end
    end

    // Displayed patterns built from next-state values so a write shows right after its edge.
    always_comb begin
        segs_nxt_s = '0;
        for (int d = 0; d < DIGITS; d++) begin
            segs_nxt_s[d] = shown_segs(frame_nxt_s[d], phase_nxt_s, BLANK_SEGS);
        end
    end

    // Frame buffer, arbitration pointer, blink timer and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r       <= {DIGITS{BLANK_ENTRY}};
            ptr_r         <= 1'b0;
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
            segs_out_r    <= {DIGITS{BLANK_SEGS}};
        end else begin
            frame_r       <= frame_nxt_s;
            blink_cnt_r   <= cnt_wrap_s ? '0 : blink_cnt_r + CNT_W'(1);
            blink_phase_r <= phase_nxt_s;
            segs_out_r    <= segs_nxt_s;
            if (xfer_s) begin
                ptr_r <= ~gnt_idx_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign segs_out    = segs_out_r;
    assign blink_phase = blink_phase_r;

endmodule

// File: tb/tb_seg_frame_ctrl.sv
// Directed and randomised bench for seg_frame_ctrl with a frame-model scoreboard.
`timescale 1ns/1ps
module tb_seg_frame_ctrl;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic [1:0]       wr_valid = 2'b00;
    logic [1:0]       wr_ready;
    logic [1:0][2:0]  wr_digit = '0;
    logic [1:0][6:0]  wr_segs = '0;
    logic [1:0]       wr_blink = 2'b00;
    logic [7:0][6:0]  segs_out;
    logic             blink_phase;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [55:0] segs;
        logic [7:0]  blink;
    } exp_t;

    exp_t            sb_q[$];
    logic [7:0][6:0] m_segs;
    logic [7:0]      m_blink;
    logic            m_ptr;
    int              m_edges;

    seg_frame_ctrl #(.BLINK_HALF_CYCLES(N), .BLANK_SEGS(7'h7F)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_digit    (wr_digit),
        .wr_segs     (wr_segs),
        .wr_blink    (wr_blink),
        .segs_out    (segs_out),
        .blink_phase (blink_phase)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; blink phase is derived from this count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_edges <= 0;
        else        m_edges <= m_edges + 1;
    end

    task automatic chk(input string tag, input logic [55:0] obs, input logic [55:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] shown(input exp_t e, input logic ph);
        logic [55:0] r;
        for (int d = 0; d < 8; d++) begin
            r[d*7 +: 7] = (e.blink[d] && ph) ? 7'h7F : e.segs[d*7 +: 7];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_segs  = {8{7'h7F}};
        m_blink = 8'h00;
        m_ptr   = 1'b0;
        sb_q.delete();
    endtask

    // One cycle: drive at negedge, check ready, push expectation, check outputs after the edge.
    task automatic step(input string tag, input logic [1:0] v,
                        input logic [2:0] d0, input logic [6:0] s0, input logic b0,
                        input logic [2:0] d1, input logic [6:0] s1, input logic b1,
                        input logic c);
        logic [1:0] g;
        logic       ph;
        exp_t       e;
        wr_valid    = v;
        wr_digit[0] = d0; wr_segs[0] = s0; wr_blink[0] = b0;
        wr_digit[1] = d1; wr_segs[1] = s1; wr_blink[1] = b1;
        clr         = c;
        g = 2'b00;
        if (!c) begin
            if (v == 2'b01)      g = 2'b01;
            else if (v == 2'b10) g = 2'b10;
            else if (v == 2'b11) g = m_ptr ? 2'b10 : 2'b01;
        end
        #1;
        chk({tag, ".ready"}, 56'(wr_ready), 56'(g));
        if (c) begin
            m_segs  = {8{7'h7F}};
            m_blink = 8'h00;
        end else if (g == 2'b01) begin
            m_segs[d0] = s0; m_blink[d0] = b0; m_ptr = 1'b1;
        end else if (g == 2'b10) begin
            m_segs[d1] = s1; m_blink[d1] = b1; m_ptr = 1'b0;
        end
        e.segs  = m_segs;
        e.blink = m_blink;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e  = sb_q.pop_front();
        ph = ((m_edges / N) % 2) == 1;
        chk({tag, ".phase"}, 56'(blink_phase), 56'(ph));
        chk({tag, ".segs"}, segs_out, shown(e, ph));
    endtask

    initial begin
        logic [55:0] all_blank;
        all_blank = {8{7'h7F}};
        model_reset();

        // Reset: ready held low even with both requesters valid.
        wr_valid = 2'b11;
        @(negedge clk);
        chk("rst.ready", 56'(wr_ready), 56'h0);
        chk("rst.segs", segs_out, all_blank);
        chk("rst.phase", 56'(blink_phase), 56'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Both valid from reset: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            step("rr", 2'b11, 3'd0, 7'h79, 1'b0, 3'd1, 7'h24, 1'b0, 1'b0);
        end
        step("idle", 2'b00, 3'd0, 7'h00, 1'b0, 3'd0, 7'h00, 1'b0, 1'b0);

        // Single requester writes, with junk on the idle requester.
        step("w0", 2'b01, 3'd3, 7'h40, 1'b0, 3'd7, 7'h01, 1'b1, 1'b0);
        step("w1", 2'b10, 3'd6, 7'h01, 1'b1, 3'd2, 7'h30, 1'b0, 1'b0);

        // Clear beats two simultaneous writes; pointer is untouched.
        step("clr", 2'b11, 3'd0, 7'h00, 1'b0, 3'd1, 7'h00, 1'b0, 1'b1);
        step("post_clr", 2'b11, 3'd4, 7'h11, 1'b0, 3'd4, 7'h22, 1'b0, 1'b0);
        step("same_dig", 2'b11, 3'd4, 7'h11, 1'b0, 3'd4, 7'h22, 1'b0, 1'b0);

        // Blinking digit 5 alongside steady digits.
        step("blink_w", 2'b01, 3'd5, 7'h12, 1'b1, 3'd0, 7'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step("blink", 2'b00, 3'd0, 7'h00, 1'b0, 3'd0, 7'h00, 1'b0, 1'b0);
        end

        // Reset pulse mid-stream with req1 valid: write dropped, pointer back to req0.
        wr_valid    = 2'b10;
        wr_digit[1] = 3'd2;
        wr_segs[1]  = 7'h00;
        rst_n       = 1'b0;
        model_reset();
        #1;
        chk("mid_rst.ready", 56'(wr_ready), 56'h0);
        chk("mid_rst.segs", segs_out, all_blank);
        chk("mid_rst.phase", 56'(blink_phase), 56'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("after_rst", 2'b11, 3'd2, 7'h08, 1'b0, 3'd3, 7'h09, 1'b0, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 40; i++) begin
            step("rnd", 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
